// File: rtl/issue_stage.sv
// ---------------------------------------------------------------------------
// issue_stage
//
// Decodes one RV32I instruction per cycle, resolves its source operands
// against the register file and the ROB, predicts conditional branches with
// a table of 2-bit saturating counters, and emits a registered issue packet
// that goes to the reservation stations, the load/store buffer, or the ROB
// only.
//
// Handshake: an instruction is taken from the fetcher in the cycle where
// inst_valid and inst_ready are both high. inst_ready is combinational and
// never depends on inst_ready itself. A taken, recognised instruction shows
// up on iss_* exactly one cycle later with iss_valid high for that single
// cycle. iss_valid has no ready: downstream units advertise space through
// rob_full / rs_full / lsb_full before the instruction is taken.
//
// Ports
//   clk_in, rst_in            clock, asynchronous active-high reset
//   rdy_in                    global pause (freezes state, blocks accept)
//   inst_valid/inst/inst_addr fetched instruction and its PC
//   inst_ready                instruction taken this cycle
//   next_pc_valid/next_pc     fetch redirect, valid only on accept
//   rs1_id/rs2_id             register file query
//   rs*_val/rs*_has_dep/rs*_dep register file reply (same cycle)
//   rob_qry*_id               ROB readiness query (from rs*_dep)
//   rob_qry*_fi/rob_qry*_value ROB readiness reply (same cycle)
//   rob_full/rs_full/lsb_full back-pressure
//   rob_vacant_id             ROB tag for the instruction being issued
//   flush                     misprediction clear
//   bht_upd_*                 resolved-branch training
//   iss_*                     registered issue packet
// ---------------------------------------------------------------------------
module issue_stage #(
    parameter int         ROB_SIZE_BIT = 3,
    parameter int         BHT_BITS     = 6,
    parameter logic [1:0] BHT_INIT     = 2'b01
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,

    input  logic                    inst_valid,
    input  logic [31:0]             inst,
    input  logic [31:0]             inst_addr,
    output logic                    inst_ready,
    output logic                    next_pc_valid,
    output logic [31:0]             next_pc,

    output logic [4:0]              rs1_id,
    output logic [4:0]              rs2_id,
    input  logic [31:0]             rs1_val,
    input  logic [31:0]             rs2_val,
    input  logic                    rs1_has_dep,
    input  logic                    rs2_has_dep,
    input  logic [ROB_SIZE_BIT-1:0] rs1_dep,
    input  logic [ROB_SIZE_BIT-1:0] rs2_dep,

    output logic [ROB_SIZE_BIT-1:0] rob_qry1_id,
    output logic [ROB_SIZE_BIT-1:0] rob_qry2_id,
    input  logic                    rob_qry1_fi,
    input  logic                    rob_qry2_fi,
    input  logic [31:0]             rob_qry1_value,
    input  logic [31:0]             rob_qry2_value,

    input  logic                    rob_full,
    input  logic                    rs_full,
    input  logic                    lsb_full,
    input  logic [ROB_SIZE_BIT-1:0] rob_vacant_id,
    input  logic                    flush,

    input  logic                    bht_upd_valid,
    input  logic [31:0]             bht_upd_pc,
    input  logic                    bht_upd_taken,

    output logic                    iss_valid,
    output logic [1:0]              iss_unit,
    output logic [4:0]              iss_op,
    output logic [31:0]             iss_v1,
    output logic [31:0]             iss_v2,
    output logic [31:0]             iss_imm,
    output logic                    iss_has_q1,
    output logic                    iss_has_q2,
    output logic [ROB_SIZE_BIT-1:0] iss_q1,
    output logic [ROB_SIZE_BIT-1:0] iss_q2,
    output logic [ROB_SIZE_BIT-1:0] iss_rob_id,
    output logic [4:0]              iss_rd,
    output logic                    iss_fi,
    output logic                    iss_pred,
    output logic [31:0]             iss_alt_pc
);

    localparam int BHT_SIZE = 1 << BHT_BITS;

    localparam logic [1:0] UNIT_RS  = 2'd0;
    localparam logic [1:0] UNIT_LSB = 2'd1;
    localparam logic [1:0] UNIT_ROB = 2'd2;

    typedef enum logic [3:0] {
        K_OP, K_OPIMM, K_LOAD, K_STORE, K_BR,
        K_LUI, K_AUIPC, K_JAL, K_JALR, K_BAD
    } kind_e;

    typedef struct packed {
        logic                    has_q;
        logic [ROB_SIZE_BIT-1:0] q;
        logic [31:0]             v;
    } opnd_t;

    typedef struct packed {
        logic [1:0]              unit;
        logic [4:0]              op;
        logic [31:0]             v1;
        logic [31:0]             v2;
        logic [31:0]             imm;
        logic                    has_q1;
        logic                    has_q2;
        logic [ROB_SIZE_BIT-1:0] q1;
        logic [ROB_SIZE_BIT-1:0] q2;
        logic [ROB_SIZE_BIT-1:0] rob_id;
        logic [4:0]              rd;
        logic                    fi;
        logic                    pred;
        logic [31:0]             alt_pc;
    } pkt_t;

    // -----------------------------------------------------------------------
    // Field extraction and immediates
    // -----------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic        func7_b5;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] pc_plus4;

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign func3    = inst[14:12];
    assign func7_b5 = inst[30];
    assign rs1_id   = inst[19:15];
    assign rs2_id   = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign pc_plus4 = inst_addr + 32'd4;

    kind_e kind;

    always_comb begin
        kind = K_BAD;
        case (opcode)
            7'b0110011: kind = K_OP;
            7'b0010011: kind = K_OPIMM;
            7'b0000011: kind = K_LOAD;
            7'b0100011: kind = K_STORE;
            7'b1100011: kind = K_BR;
            7'b0110111: kind = K_LUI;
            7'b0010111: kind = K_AUIPC;
            7'b1101111: kind = K_JAL;
            7'b1100111: kind = K_JALR;
            default:    kind = K_BAD;
        endcase
    end

    logic known;
    logic use_rs1;
    logic use_rs2;
    logic to_rs;
    logic to_lsb;

    assign known   = (kind != K_BAD);
    assign to_rs   = (kind == K_OP) || (kind == K_OPIMM) || (kind == K_BR);
    assign to_lsb  = (kind == K_LOAD) || (kind == K_STORE);
    assign use_rs1 = to_rs || to_lsb;
    assign use_rs2 = (kind == K_OP) || (kind == K_STORE) || (kind == K_BR);

    // -----------------------------------------------------------------------
    // Operand resolution: x0, register file, finished ROB entry, or tag
    // -----------------------------------------------------------------------
    function automatic opnd_t resolve_src(
        input logic [4:0]              id,
        input logic [31:0]             rf_val,
        input logic                    has_dep,
        input logic [ROB_SIZE_BIT-1:0] dep,
        input logic                    rob_fi,
        input logic [31:0]             rob_val
    );
        opnd_t r;
        r = '0;
        if (id == 5'd0) begin
            r = '0;
        end else if (!has_dep) begin
            r.v = rf_val;
        end else if (rob_fi) begin
            r.v = rob_val;
        end else begin
            r.has_q = 1'b1;
            r.q     = dep;
        end
        return r;
    endfunction

    assign rob_qry1_id = rs1_dep;
    assign rob_qry2_id = rs2_dep;

    opnd_t src1;
    opnd_t src2;

    assign src1 = resolve_src(rs1_id, rs1_val, rs1_has_dep, rs1_dep, rob_qry1_fi, rob_qry1_value);
    assign src2 = resolve_src(rs2_id, rs2_val, rs2_has_dep, rs2_dep, rob_qry2_fi, rob_qry2_value);

    // -----------------------------------------------------------------------
    // Branch history table
    // -----------------------------------------------------------------------
    logic [1:0]          bht [BHT_SIZE];
    logic [BHT_BITS-1:0] bht_rd_idx;
    logic [BHT_BITS-1:0] bht_wr_idx;
    logic [1:0]          bht_ctr;
    logic                pred;

    assign bht_rd_idx = inst_addr[BHT_BITS+1:2];
    assign bht_wr_idx = bht_upd_pc[BHT_BITS+1:2];
    // Read is taken from the registered array, so a same-cycle update to
    // the same entry is only visible from the next cycle on.
    assign bht_ctr    = bht[bht_rd_idx];
    assign pred       = bht_ctr[1];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (rdy_in && bht_upd_valid) begin
            if (bht_upd_taken) begin
                if (bht[bht_wr_idx] != 2'd3) begin
                    bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'd1;
                end
            end else begin
                if (bht[bht_wr_idx] != 2'd0) begin
                    bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'd1;
                end
            end
        end
    end

    // Only the index bits of the training PC take part.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{bht_upd_pc[31:BHT_BITS+2], bht_upd_pc[1:0]};

    // -----------------------------------------------------------------------
    // Stall and accept
    // -----------------------------------------------------------------------
    logic rs1_resolved;
    logic stall;

    assign rs1_resolved = !src1.has_q;

    // JALR must know its target before fetch can be redirected, so it waits
    // for rs1 rather than carrying a tag.
    assign stall = !rdy_in || flush || rob_full
                 || (to_rs && rs_full)
                 || (to_lsb && lsb_full)
                 || ((kind == K_JALR) && !rs1_resolved);

    assign inst_ready = inst_valid && !stall;

    // -----------------------------------------------------------------------
    // Redirect, asserted only in the accept cycle
    // -----------------------------------------------------------------------
    always_comb begin
        next_pc_valid = 1'b0;
        next_pc       = pc_plus4;
        if (inst_ready) begin
            case (kind)
                K_JAL: begin
                    next_pc_valid = 1'b1;
                    next_pc       = inst_addr + imm_j;
                end
                K_JALR: begin
                    next_pc_valid = 1'b1;
                    next_pc       = (src1.v + imm_i) & ~32'd1;
                end
                K_BR: begin
                    next_pc_valid = pred;
                    next_pc       = pred ? (inst_addr + imm_b) : pc_plus4;
                end
                default: begin
                    next_pc_valid = 1'b0;
                    next_pc       = pc_plus4;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Packet assembly
    // -----------------------------------------------------------------------
    pkt_t pkt_d;
    pkt_t pkt_q;

    always_comb begin
        pkt_d        = '0;
        pkt_d.rob_id = rob_vacant_id;
        pkt_d.rd     = rd;

        if (use_rs1) begin
            pkt_d.has_q1 = src1.has_q;
            pkt_d.q1     = src1.q;
            pkt_d.v1     = src1.v;
        end
        if (use_rs2) begin
            pkt_d.has_q2 = src2.has_q;
            pkt_d.q2     = src2.q;
            pkt_d.v2     = src2.v;
        end

        case (kind)
            K_OP: begin
                pkt_d.unit = UNIT_RS;
                pkt_d.op   = {1'b0, func3, func7_b5};
            end
            K_OPIMM: begin
                pkt_d.unit = UNIT_RS;
                // inst[30] only selects an operation for shifts; otherwise
                // it is an immediate bit and must not look like SUB/SRA.
                pkt_d.op   = {1'b0, func3,
                              ((func3 == 3'b001) || (func3 == 3'b101)) ? func7_b5 : 1'b0};
                pkt_d.v2   = imm_i;
                pkt_d.imm  = imm_i;
            end
            K_LOAD: begin
                pkt_d.unit = UNIT_LSB;
                pkt_d.op   = {1'b0, 1'b0, func3};
                pkt_d.imm  = imm_i;
            end
            K_STORE: begin
                pkt_d.unit = UNIT_LSB;
                pkt_d.op   = {1'b0, 1'b1, func3};
                pkt_d.imm  = imm_s;
                pkt_d.rd   = 5'd0;
            end
            K_BR: begin
                pkt_d.unit   = UNIT_RS;
                pkt_d.op     = {1'b1, func3, 1'b0};
                pkt_d.imm    = imm_b;
                pkt_d.rd     = 5'd0;
                pkt_d.pred   = pred;
                pkt_d.alt_pc = pred ? pc_plus4 : (inst_addr + imm_b);
            end
            K_LUI: begin
                pkt_d.unit = UNIT_ROB;
                pkt_d.fi   = 1'b1;
                pkt_d.v1   = imm_u;
            end
            K_AUIPC: begin
                pkt_d.unit = UNIT_ROB;
                pkt_d.fi   = 1'b1;
                pkt_d.v1   = inst_addr + imm_u;
            end
            K_JAL: begin
                pkt_d.unit = UNIT_ROB;
                pkt_d.fi   = 1'b1;
                pkt_d.v1   = pc_plus4;
            end
            K_JALR: begin
                pkt_d.unit = UNIT_ROB;
                pkt_d.fi   = 1'b1;
                pkt_d.v1   = pc_plus4;
                pkt_d.imm  = imm_i;
            end
            default: begin
                pkt_d.unit = UNIT_RS;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Issue register. Fields hold between issues; iss_valid marks freshness.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            iss_valid <= 1'b0;
            pkt_q     <= '0;
        end else begin
            iss_valid <= inst_ready && known;
            if (inst_ready && known) begin
                pkt_q <= pkt_d;
            end
        end
    end

    assign iss_unit   = pkt_q.unit;
    assign iss_op     = pkt_q.op;
    assign iss_v1     = pkt_q.v1;
    assign iss_v2     = pkt_q.v2;
    assign iss_imm    = pkt_q.imm;
    assign iss_has_q1 = pkt_q.has_q1;
    assign iss_has_q2 = pkt_q.has_q2;
    assign iss_q1     = pkt_q.q1;
    assign iss_q2     = pkt_q.q2;
    assign iss_rob_id = pkt_q.rob_id;
    assign iss_rd     = pkt_q.rd;
    assign iss_fi     = pkt_q.fi;
    assign iss_pred   = pkt_q.pred;
    assign iss_alt_pc = pkt_q.alt_pc;

endmodule

// File: tb/tb_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_issue_stage: directed scenarios followed by randomized traffic.
// A reference model evaluates each cycle's inputs at the falling edge,
// checks the combinational outputs, and queues the expected issue packet.
// A monitor checks the registered issue outputs after every rising edge.
// ---------------------------------------------------------------------------
module tb_issue_stage;

  localparam int RB = 3;
  localparam int BHT_N = 64;

  typedef struct packed {
    logic [1:0]    unit;
    logic [4:0]    op;
    logic [31:0]   v1;
    logic [31:0]   v2;
    logic [31:0]   imm;
    logic          has_q1;
    logic          has_q2;
    logic [RB-1:0] q1;
    logic [RB-1:0] q2;
    logic [RB-1:0] rob_id;
    logic [4:0]    rd;
    logic          fi;
    logic          pred;
    logic [31:0]   alt_pc;
  } pkt_t;

  localparam int PW = $bits(pkt_t);

  localparam logic [6:0] OPC_TAB [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                          7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};

  logic clk_in, rst_in, rdy_in;
  logic inst_valid;
  logic [31:0] inst, inst_addr;
  logic inst_ready, next_pc_valid;
  logic [31:0] next_pc;
  logic [4:0] rs1_id, rs2_id;
  logic [31:0] rs1_val, rs2_val;
  logic rs1_has_dep, rs2_has_dep;
  logic [RB-1:0] rs1_dep, rs2_dep, rob_qry1_id, rob_qry2_id;
  logic rob_qry1_fi, rob_qry2_fi;
  logic [31:0] rob_qry1_value, rob_qry2_value;
  logic rob_full, rs_full, lsb_full;
  logic [RB-1:0] rob_vacant_id;
  logic flush;
  logic bht_upd_valid, bht_upd_taken;
  logic [31:0] bht_upd_pc;
  logic iss_valid;
  logic [1:0] iss_unit;
  logic [4:0] iss_op, iss_rd;
  logic [31:0] iss_v1, iss_v2, iss_imm, iss_alt_pc;
  logic iss_has_q1, iss_has_q2, iss_fi, iss_pred;
  logic [RB-1:0] iss_q1, iss_q2, iss_rob_id;

  issue_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .next_pc_valid(next_pc_valid), .next_pc(next_pc),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_has_dep(rs1_has_dep), .rs2_has_dep(rs2_has_dep),
    .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .rob_qry1_id(rob_qry1_id), .rob_qry2_id(rob_qry2_id),
    .rob_qry1_fi(rob_qry1_fi), .rob_qry2_fi(rob_qry2_fi),
    .rob_qry1_value(rob_qry1_value), .rob_qry2_value(rob_qry2_value),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_vacant_id(rob_vacant_id), .flush(flush),
    .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
    .iss_valid(iss_valid), .iss_unit(iss_unit), .iss_op(iss_op),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_imm(iss_imm),
    .iss_has_q1(iss_has_q1), .iss_has_q2(iss_has_q2), .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_rob_id(iss_rob_id), .iss_rd(iss_rd), .iss_fi(iss_fi), .iss_pred(iss_pred),
    .iss_alt_pc(iss_alt_pc)
  );

  // ---------------- clock ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [PW-1:0] exp_q[$];
  int bht_m [BHT_N];
  pkt_t got_pkt;

  assign got_pkt = '{unit: iss_unit, op: iss_op, v1: iss_v1, v2: iss_v2, imm: iss_imm,
                     has_q1: iss_has_q1, has_q2: iss_has_q2, q1: iss_q1, q2: iss_q2,
                     rob_id: iss_rob_id, rd: iss_rd, fi: iss_fi, pred: iss_pred,
                     alt_pc: iss_alt_pc};

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_imm_i(input logic [31:0] w);
    return 32'($signed(w) >>> 20);
  endfunction
  function automatic logic [31:0] m_imm_s(input logic [31:0] w);
    return 32'(($signed(w) >>> 25) <<< 5) | {27'd0, w[11:7]};
  endfunction
  function automatic logic [31:0] m_imm_b(input logic [31:0] w);
    int v;
    v = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
    return 32'(v);
  endfunction
  function automatic logic [31:0] m_imm_j(input logic [31:0] w);
    int v;
    v = (w[31] ? -(1 << 20) : 0) + 4096 * int'(w[19:12]) + (w[20] ? 2048 : 0) + 2 * int'(w[30:21]);
    return 32'(v);
  endfunction

  function automatic void m_resolve(input logic [4:0] id, input logic [31:0] rf, input logic hd,
                                    input logic [RB-1:0] dep, input logic fi, input logic [31:0] rv,
                                    output logic hq, output logic [RB-1:0] q, output logic [31:0] v);
    hq = 1'b0; q = '0; v = 32'd0;
    if (id == 5'd0) v = 32'd0;
    else if (!hd) v = rf;
    else if (fi) v = rv;
    else begin hq = 1'b1; q = dep; end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_N; i++) bht_m[i] = 1;
    exp_q.delete();
  endtask

  task automatic model_check();
    logic [6:0] opc;
    logic [2:0] f3;
    logic [31:0] pc;
    pkt_t e;
    int unit_c;
    bit known, use1, use2, m_pred, ready, exp_nv;
    logic hq1, hq2;
    logic [RB-1:0] q1, q2;
    logic [31:0] r1v, r2v, exp_npc;
    int idx;
    if (rst_in) return;
    opc = inst[6:0];
    f3 = inst[14:12];
    pc = inst_addr;
    e = '0;
    e.rob_id = rob_vacant_id;
    e.rd = inst[11:7];
    known = 1; use1 = 0; use2 = 0; unit_c = 3;
    idx = int'(inst_addr[7:2]);
    m_pred = (bht_m[idx] >= 2);
    m_resolve(inst[19:15], rs1_val, rs1_has_dep, rs1_dep, rob_qry1_fi, rob_qry1_value, hq1, q1, r1v);
    m_resolve(inst[24:20], rs2_val, rs2_has_dep, rs2_dep, rob_qry2_fi, rob_qry2_value, hq2, q2, r2v);
    case (opc)
      7'h33: begin unit_c = 0; e.op = {1'b0, f3, inst[30]}; use1 = 1; use2 = 1; end
      7'h13: begin
        unit_c = 0; use1 = 1;
        e.op = {1'b0, f3, (f3 == 3'd1 || f3 == 3'd5) ? inst[30] : 1'b0};
        e.v2 = m_imm_i(inst); e.imm = m_imm_i(inst);
      end
      7'h03: begin unit_c = 1; e.op = {2'b00, f3}; use1 = 1; e.imm = m_imm_i(inst); end
      7'h23: begin unit_c = 1; e.op = {2'b01, f3}; use1 = 1; use2 = 1; e.imm = m_imm_s(inst); e.rd = 0; end
      7'h63: begin
        unit_c = 0; e.op = {1'b1, f3, 1'b0}; use1 = 1; use2 = 1;
        e.imm = m_imm_b(inst); e.rd = 0; e.pred = m_pred;
        e.alt_pc = m_pred ? pc + 4 : pc + m_imm_b(inst);
      end
      7'h37: begin unit_c = 2; e.fi = 1; e.v1 = inst & 32'hFFFF_F000; end
      7'h17: begin unit_c = 2; e.fi = 1; e.v1 = pc + (inst & 32'hFFFF_F000); end
      7'h6F: begin unit_c = 2; e.fi = 1; e.v1 = pc + 4; end
      7'h67: begin unit_c = 2; e.fi = 1; e.v1 = pc + 4; e.imm = m_imm_i(inst); end
      default: known = 0;
    endcase
    e.unit = (unit_c == 3) ? 2'd0 : 2'(unit_c);
    if (use1) begin e.has_q1 = hq1; e.q1 = q1; e.v1 = r1v; end
    if (use2) begin e.has_q2 = hq2; e.q2 = q2; e.v2 = r2v; end

    ready = inst_valid && rdy_in && !flush && !rob_full
            && !(unit_c == 0 && rs_full) && !(unit_c == 1 && lsb_full)
            && !(opc == 7'h67 && hq1);
    chk("inst_ready", inst_ready, ready);
    chk("query_ids", {rs1_id, rs2_id, rob_qry1_id, rob_qry2_id},
        {inst[19:15], inst[24:20], rs1_dep, rs2_dep});

    exp_nv = ready && (opc == 7'h6F || opc == 7'h67 || (opc == 7'h63 && m_pred));
    exp_npc = (opc == 7'h6F) ? pc + m_imm_j(inst)
            : (opc == 7'h67) ? ((r1v + m_imm_i(inst)) & ~32'd1)
            : pc + m_imm_b(inst);
    chk("next_pc_valid", next_pc_valid, exp_nv);
    if (exp_nv) chk("next_pc", next_pc, exp_npc);

    if (ready && known) exp_q.push_back(e);

    if (rdy_in && bht_upd_valid) begin
      idx = int'(bht_upd_pc[7:2]);
      if (bht_upd_taken) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
      else bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
    end
  endtask

  // ---------------- monitor ----------------
  logic [PW-1:0] mon_e;
  always @(posedge clk_in) begin
    #3;
    if (rst_in) begin
      chk("reset_iss_valid", iss_valid, 1'b0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("iss_valid_expected", iss_valid, 1'b1);
      if (iss_valid) chk("iss_packet", got_pkt, mon_e);
    end else begin
      chk("iss_valid_idle", iss_valid, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rdy_in = 1; inst_valid = 0; inst = 32'h0000_0013; inst_addr = 32'h0;
    rs1_val = 32'hDEAD_BEEF; rs2_val = 32'hCAFE_F00D;
    rs1_has_dep = 0; rs2_has_dep = 0; rs1_dep = 0; rs2_dep = 0;
    rob_qry1_fi = 0; rob_qry2_fi = 0; rob_qry1_value = 0; rob_qry2_value = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rob_vacant_id = 3'd5; flush = 0;
    bht_upd_valid = 0; bht_upd_pc = 0; bht_upd_taken = 0;
  endtask

  task automatic half_step();
    @(negedge clk_in);
    model_check();
  endtask

  task automatic finish_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic step();
    half_step();
    finish_step();
  endtask

  task automatic drive_random();
    logic [31:0] w;
    w = $urandom();
    inst = {w[31:7], OPC_TAB[$urandom_range(0, 9)]};
    inst_addr = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
    inst_valid = ($urandom_range(0, 4) != 0);
    rdy_in = ($urandom_range(0, 19) != 0);
    flush = ($urandom_range(0, 19) == 0);
    rob_full = ($urandom_range(0, 9) == 0);
    rs_full = ($urandom_range(0, 4) == 0);
    lsb_full = ($urandom_range(0, 4) == 0);
    rs1_val = $urandom(); rs2_val = $urandom();
    rs1_has_dep = ($urandom_range(0, 2) == 0); rs2_has_dep = ($urandom_range(0, 2) == 0);
    rs1_dep = 3'($urandom()); rs2_dep = 3'($urandom());
    rob_qry1_fi = 1'($urandom()); rob_qry2_fi = 1'($urandom());
    rob_qry1_value = $urandom(); rob_qry2_value = $urandom();
    rob_vacant_id = 3'($urandom());
    bht_upd_valid = ($urandom_range(0, 2) == 0);
    bht_upd_pc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
    bht_upd_taken = ($urandom_range(0, 2) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in = 1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_packet", got_pkt, '0);
    chk("reset_valid", iss_valid, 1'b0);
    rst_in = 0;

    // addi x1,x0,5 @0x100
    set_idle(); inst_valid = 1; inst = 32'h0050_0093; inst_addr = 32'h100;
    step();
    chk("addi_valid", iss_valid, 1'b1);
    chk("addi_fields", {iss_unit, iss_v1, iss_v2, iss_has_q1, iss_rd},
        {2'd0, 32'd0, 32'd5, 1'b0, 5'd1});

    // add x3,x1,x2 with one pending and one finished dependency
    set_idle(); inst_valid = 1; inst = 32'h0020_81B3; inst_addr = 32'h104;
    rs1_has_dep = 1; rs1_dep = 3'd2; rob_qry1_fi = 0;
    rs2_has_dep = 1; rs2_dep = 3'd4; rob_qry2_fi = 1; rob_qry2_value = 32'd7;
    step();
    chk("add_deps", {iss_has_q1, iss_q1, iss_has_q2, iss_v2}, {1'b1, 3'd2, 1'b0, 32'd7});

    // beq @0x200, +16, weakly not-taken counter
    set_idle(); inst_valid = 1; inst = 32'h0020_8863; inst_addr = 32'h200;
    half_step();
    chk("beq_nt_redirect", next_pc_valid, 1'b0);
    finish_step();
    chk("beq_nt_pkt", {iss_pred, iss_alt_pc}, {1'b0, 32'h210});
    set_idle(); bht_upd_valid = 1; bht_upd_pc = 32'h200; bht_upd_taken = 1;
    step(); step();
    set_idle(); inst_valid = 1; inst = 32'h0020_8863; inst_addr = 32'h200;
    half_step();
    chk("beq_t_redirect", {next_pc_valid, next_pc}, {1'b1, 32'h210});
    finish_step();
    chk("beq_t_pkt", {iss_pred, iss_alt_pc}, {1'b1, 32'h204});

    // jalr x1,0(x5) waiting on rs1
    set_idle(); inst_valid = 1; inst = 32'h0002_80E7; inst_addr = 32'h400;
    rs1_has_dep = 1; rs1_dep = 3'd3; rob_qry1_fi = 0;
    for (int i = 0; i < 3; i++) begin
      half_step();
      chk("jalr_wait", inst_ready, 1'b0);
      finish_step();
    end
    rob_qry1_fi = 1; rob_qry1_value = 32'h301;
    half_step();
    chk("jalr_go", {inst_ready, next_pc_valid, next_pc}, {1'b1, 1'b1, 32'h300});
    finish_step();

    // sw x2,0(x1) behind a full LSB
    set_idle(); inst_valid = 1; inst = 32'h0020_A023; inst_addr = 32'h500; lsb_full = 1;
    half_step();
    chk("sw_blocked", inst_ready, 1'b0);
    finish_step();
    chk("sw_no_issue", iss_valid, 1'b0);
    lsb_full = 0;
    half_step();
    chk("sw_ready", inst_ready, 1'b1);
    finish_step();
    chk("sw_issue", {iss_valid, iss_unit, iss_op[3]}, {1'b1, 2'd1, 1'b1});

    // flush drops the instruction but training continues
    set_idle(); inst_valid = 1; inst = 32'h0050_0093; inst_addr = 32'h108; flush = 1;
    bht_upd_valid = 1; bht_upd_pc = 32'h204; bht_upd_taken = 1;
    half_step();
    chk("flush_ready", inst_ready, 1'b0);
    finish_step();
    chk("flush_no_issue", iss_valid, 1'b0);

    // reset in the middle of an issue
    set_idle(); inst_valid = 1; inst = 32'h0050_0093; inst_addr = 32'h10C;
    step();
    chk("pre_reset_valid", iss_valid, 1'b1);
    rst_in = 1;
    exp_q.delete();
    model_reset();
    inst_valid = 0;
    #1;
    chk("async_reset_valid", iss_valid, 1'b0);
    chk("async_reset_packet", got_pkt, '0);
    @(posedge clk_in);
    #1;
    rst_in = 0;
    set_idle(); inst_valid = 1; inst = 32'h0020_8863; inst_addr = 32'h200;
    half_step();
    chk("bht_after_reset", next_pc_valid, 1'b0);
    finish_step();
    chk("bht_after_reset_pred", iss_pred, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      step();
    end

    set_idle();
    step(); step();
    chk("queue_drained", 160'(exp_q.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
